// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-execute bundle of the decode stage: input handshake, flush, decoded outputs.
// The interface adds no registers and no latency of its own.
// Backpressure: in_ready_o and out_ready_i carry the valid/ready flow control.
interface decode_stage_pipe_if #(
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [INSTR_SIZE-1:0] instr_i;
  logic [PC_W-1:0]       pc_i;
  logic                  flush_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  ctrl_op_o;
  logic                  ctrl_ld_o;
  logic                  ctrl_st_o;
  logic                  ctrl_jm_o;
  logic                  ctrl_br_o;
  logic                  ctrl_illegal_o;
  logic [4:0]            rs1_o;
  logic [4:0]            rs2_o;
  logic [4:0]            rd_o;
  logic                  use_rs1_o;
  logic                  use_rs2_o;
  logic                  rd_we_o;
  logic [2:0]            funct3_o;
  logic [6:0]            funct7_o;
  logic [XLEN-1:0]       imm_o;
  logic [PC_W-1:0]       pc_o;
  logic [CNT_W-1:0]      bubble_cnt_o;

  // Decode stage side.
  modport slave (
    input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o,
    output ctrl_op_o, ctrl_ld_o, ctrl_st_o, ctrl_jm_o, ctrl_br_o, ctrl_illegal_o,
    output rs1_o, rs2_o, rd_o, use_rs1_o, use_rs2_o, rd_we_o,
    output funct3_o, funct7_o, imm_o, pc_o, bubble_cnt_o
  );

  // Fetch/execute side.
  modport master (
    output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  ctrl_op_o, ctrl_ld_o, ctrl_st_o, ctrl_jm_o, ctrl_br_o, ctrl_illegal_o,
    input  rs1_o, rs2_o, rd_o, use_rs1_o, use_rs2_o, rd_we_o,
    input  funct3_o, funct7_o, imm_o, pc_o, bubble_cnt_o
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered decode: one-hot class, register fields, sign-extended immediate, load-use bubble.
// Latency 1 cycle; one instruction per cycle when no hazard and execute is ready.
// Backpressure: in_ready_o drops while the held result is stalled, on a load-use hazard, or on flush.
module decode_stage_pipe #(
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  decode_stage_pipe_if.slave     bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LD     = 7'b0000011;
  localparam logic [6:0] OPC_ST     = 7'b0100011;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [INSTR_SIZE-1:0] instr;
  assign instr = bus.instr_i;

  // Decoded view of the incoming instruction.
  logic        d_op, d_ld, d_st, d_jm, d_br, d_ill;
  logic        d_use_rs1, d_use_rs2, d_wr_class, d_rd_we;
  logic [31:0] d_imm32;
  logic [4:0]  d_rs1, d_rs2, d_rd;

  // Held (registered) state.
  logic             valid_q;
  logic             op_q, ld_q, st_q, jm_q, br_q, ill_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             use_rs1_q, use_rs2_q, rd_we_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q;
  logic [XLEN-1:0]  imm_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard, ready, accept;

  assign d_rs1 = instr[19:15];
  assign d_rs2 = instr[24:20];
  assign d_rd  = instr[11:7];

  // Classify the opcode and assemble the 32-bit immediate for its format.
  // Every legal opcode ends in 2'b11, so a bad low pair falls into the illegal default.
  always_comb begin
    d_op = 1'b0; d_ld = 1'b0; d_st = 1'b0; d_jm = 1'b0; d_br = 1'b0; d_ill = 1'b0;
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; d_wr_class = 1'b0;
    d_imm32 = '0;
    case (instr[6:0])
      OPC_OP:     begin d_op = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_wr_class = 1'b1; end
      OPC_OP_IMM: begin d_op = 1'b1; d_use_rs1 = 1'b1; d_wr_class = 1'b1;
                        d_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      OPC_LD:     begin d_ld = 1'b1; d_use_rs1 = 1'b1; d_wr_class = 1'b1;
                        d_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      OPC_ST:     begin d_st = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
                        d_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
      OPC_BR:     begin d_br = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
                        d_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}; end
      OPC_JAL:    begin d_jm = 1'b1; d_wr_class = 1'b1;
                        d_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}; end
      OPC_JALR:   begin d_jm = 1'b1; d_use_rs1 = 1'b1; d_wr_class = 1'b1;
                        d_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      OPC_LUI,
      OPC_AUIPC:  begin d_op = 1'b1; d_wr_class = 1'b1;
                        d_imm32 = {instr[31:12], 12'h000}; end
      default:    d_ill = 1'b1;
    endcase
  end

  // Writes to x0 are dropped, which also keeps x0 loads from ever causing a hazard.
  assign d_rd_we = d_wr_class & (d_rd != 5'd0);

  assign hazard = valid_q & ld_q & rd_we_q &
                  ((d_use_rs1 & (d_rs1 == rd_q)) | (d_use_rs2 & (d_rs2 == rd_q)));
  assign ready  = (~valid_q | bus.out_ready_i) & ~hazard & ~bus.flush_i;
  assign accept = bus.in_valid_i & ready;

  // Output register: flush beats accept beats drain; data fields move only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q <= 1'b0; ld_q <= 1'b0; st_q <= 1'b0; jm_q <= 1'b0; br_q <= 1'b0; ill_q <= 1'b0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      use_rs1_q <= 1'b0; use_rs2_q <= 1'b0; rd_we_q <= 1'b0;
      funct3_q <= '0; funct7_q <= '0; imm_q <= '0; pc_q <= '0;
    end else if (bus.flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      op_q <= d_op; ld_q <= d_ld; st_q <= d_st; jm_q <= d_jm; br_q <= d_br; ill_q <= d_ill;
      rs1_q <= d_rs1; rs2_q <= d_rs2; rd_q <= d_rd;
      use_rs1_q <= d_use_rs1; use_rs2_q <= d_use_rs2; rd_we_q <= d_rd_we;
      funct3_q  <= instr[14:12];
      funct7_q  <= instr[31:25];
      imm_q     <= XLEN'($signed(d_imm32));
      pc_q      <= bus.pc_i;
    end else if (bus.out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating count of cycles where a presented instruction was held back by a load-use hazard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.in_valid_i & hazard & ~bus.flush_i & (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_o     = ready;
  assign bus.out_valid_o    = valid_q;
  assign bus.ctrl_op_o      = op_q;
  assign bus.ctrl_ld_o      = ld_q;
  assign bus.ctrl_st_o      = st_q;
  assign bus.ctrl_jm_o      = jm_q;
  assign bus.ctrl_br_o      = br_q;
  assign bus.ctrl_illegal_o = ill_q;
  assign bus.rs1_o          = rs1_q;
  assign bus.rs2_o          = rs2_q;
  assign bus.rd_o           = rd_q;
  assign bus.use_rs1_o      = use_rs1_q;
  assign bus.use_rs2_o      = use_rs2_q;
  assign bus.rd_we_o        = rd_we_q;
  assign bus.funct3_o       = funct3_q;
  assign bus.funct7_o       = funct7_q;
  assign bus.imm_o          = imm_q;
  assign bus.pc_o           = pc_q;
  assign bus.bubble_cnt_o   = cnt_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus randomized stream against a reference model.
// Model advances once per clock, predicting in_ready before the edge and outputs after it.
// Backpressure, flush and hazard stalls are all driven from the stimulus.
module tb_decode_stage_pipe;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.INSTR_SIZE(32), .XLEN(32), .PC_W(32), .CNT_W(CW)) bus ();

  decode_stage_pipe #(.INSTR_SIZE(32), .XLEN(32), .PC_W(32), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        op, ld, st, jm, br, ill;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
  } dec_t;

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  dec_t        m_held;
  int          m_cnt;
  logic        last_rdy;
  dec_t        dut_dec;

  always_comb begin
    dut_dec     = '0;
    dut_dec.op  = bus.ctrl_op_o;  dut_dec.ld = bus.ctrl_ld_o; dut_dec.st = bus.ctrl_st_o;
    dut_dec.jm  = bus.ctrl_jm_o;  dut_dec.br = bus.ctrl_br_o; dut_dec.ill = bus.ctrl_illegal_o;
    dut_dec.rs1 = bus.rs1_o; dut_dec.rs2 = bus.rs2_o; dut_dec.rd = bus.rd_o;
    dut_dec.u1  = bus.use_rs1_o; dut_dec.u2 = bus.use_rs2_o; dut_dec.we = bus.rd_we_o;
    dut_dec.f3  = bus.funct3_o; dut_dec.f7 = bus.funct7_o;
    dut_dec.imm = bus.imm_o; dut_dec.pc = bus.pc_o;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode from the instruction-set rules.
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    d = '0;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    d.f3 = w[14:12]; d.f7 = w[31:25]; d.pc = pc;
    case (w[6:0])
      7'b0110011: begin d.op = 1; d.u1 = 1; d.u2 = 1; d.we = 1; end
      7'b0010011: begin d.op = 1; d.u1 = 1; d.we = 1; d.imm = 32'($signed(w[31:20])); end
      7'b0000011: begin d.ld = 1; d.u1 = 1; d.we = 1; d.imm = 32'($signed(w[31:20])); end
      7'b0100011: begin d.st = 1; d.u1 = 1; d.u2 = 1;
                        d.imm = 32'($signed({w[31:25], w[11:7]})); end
      7'b1100011: begin d.br = 1; d.u1 = 1; d.u2 = 1;
                        d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2; end
      7'b1101111: begin d.jm = 1; d.we = 1;
                        d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2; end
      7'b1100111: begin d.jm = 1; d.u1 = 1; d.we = 1; d.imm = 32'($signed(w[31:20])); end
      7'b0110111,
      7'b0010111: begin d.op = 1; d.we = 1; d.imm = w & 32'hFFFF_F000; end
      default:    d.ill = 1;
    endcase
    if (d.rd == 5'd0) d.we = 0;
    return d;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model, check outputs after posedge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic fl, input logic ordy);
    dec_t d;
    logic haz, rdy;
    @(negedge clk);
    bus.in_valid_i = v; bus.instr_i = w; bus.pc_i = pc;
    bus.flush_i = fl; bus.out_ready_i = ordy;
    d   = ref_decode(w, pc);
    haz = m_valid && m_held.ld && m_held.we &&
          ((d.u1 && d.rs1 == m_held.rd) || (d.u2 && d.rs2 == m_held.rd));
    rdy = (!m_valid || ordy) && !haz && !fl;
    #1;
    check("in_ready", bus.in_ready_o, rdy);
    last_rdy = bus.in_ready_o;
    if (v && haz && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
    if (fl) m_valid = 0;
    else if (v && rdy) begin m_held = d; m_valid = 1; end
    else if (ordy) m_valid = 0;
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid_o, m_valid);
    check("outputs", dut_dec, m_held);
    check("bubble_cnt", bus.bubble_cnt_o, m_cnt);
    if (m_valid)
      check("one_hot", $countones({bus.ctrl_op_o, bus.ctrl_ld_o, bus.ctrl_st_o,
                                   bus.ctrl_jm_o, bus.ctrl_br_o, bus.ctrl_illegal_o}), 1);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    bus.in_valid_i = 0; bus.flush_i = 0; bus.out_ready_i = 0;
    #2 reset = 1;
    #1;
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_outputs", dut_dec, '0);
    check("rst_cnt", bus.bubble_cnt_o, 0);
    check("rst_ready", bus.in_ready_o, 1);
    m_valid = 0; m_held = '0; m_cnt = 0;
    @(negedge clk);
    reset = 0;
  endtask

  localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD_567 = {7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_600 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADDI_64 = {12'd1, 5'd4, 3'b000, 5'd6, 7'b0010011};
  localparam logic [31:0] ADDI_75 = {12'd5, 5'd0, 3'b000, 5'd7, 7'b0010011};
  localparam logic [31:0] ADDI_83 = {12'd3, 5'd0, 3'b000, 5'd8, 7'b0010011};
  localparam logic [31:0] ADDI_92 = {12'd2, 5'd0, 3'b000, 5'd9, 7'b0010011};

  logic [6:0] opc_tab [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                               7'b1111111};

  initial begin
    logic [31:0] w;
    m_valid = 0; m_held = '0; m_cnt = 0; last_rdy = 0;
    bus.in_valid_i = 0; bus.instr_i = '0; bus.pc_i = '0; bus.flush_i = 0; bus.out_ready_i = 0;
    repeat (2) @(negedge clk);
    check("reset_valid", bus.out_valid_o, 0);
    check("reset_outputs", dut_dec, '0);
    check("reset_cnt", bus.bubble_cnt_o, 0);
    check("reset_ready", bus.in_ready_o, 1);
    reset = 0;

    // Back-to-back stream at full rate.
    step(1, 32'hFFF00093, 32'h100, 0, 1);
    check("addi_ready", last_rdy, 1);
    check("addi_class", bus.ctrl_op_o, 1);
    check("addi_imm", bus.imm_o, 32'hFFFF_FFFF);
    step(1, 32'h00112423, 32'h104, 0, 1);
    check("sw_ready", last_rdy, 1);
    check("sw_class", bus.ctrl_st_o, 1);
    check("sw_imm", bus.imm_o, 32'h8);
    step(1, 32'hFE000EE3, 32'h108, 0, 1);
    check("beq_ready", last_rdy, 1);
    check("beq_class", bus.ctrl_br_o, 1);
    check("beq_imm", bus.imm_o, 32'hFFFF_FFFC);

    // Load-use: exactly one bubble.
    step(1, LW_X5, 32'h10C, 0, 1);
    step(1, ADD_567, 32'h110, 0, 1);
    check("lu_stall_ready", last_rdy, 0);
    check("lu_bubble_valid", bus.out_valid_o, 0);
    step(1, ADD_567, 32'h110, 0, 1);
    check("lu_accept_ready", last_rdy, 1);
    check("lu_add_rd", bus.rd_o, 6);
    check("lu_cnt", bus.bubble_cnt_o, 1);

    // No hazard through x0 or an unrelated source.
    step(1, LW_X0, 32'h114, 0, 1);
    step(1, ADD_600, 32'h118, 0, 1);
    check("x0_ready", last_rdy, 1);
    step(1, LW_X5, 32'h11C, 0, 1);
    step(1, ADDI_64, 32'h120, 0, 1);
    check("nodep_ready", last_rdy, 1);
    check("nodep_cnt", bus.bubble_cnt_o, 1);

    // Backpressure for three cycles, then release.
    step(1, ADDI_75, 32'h200, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, ADDI_83, 32'h204, 0, 0);
      check("bp_ready", last_rdy, 0);
      check("bp_pc", bus.pc_o, 32'h200);
      check("bp_valid", bus.out_valid_o, 1);
    end
    step(1, ADDI_83, 32'h204, 0, 1);
    check("bp_release_ready", last_rdy, 1);
    check("bp_release_pc", bus.pc_o, 32'h204);

    // Flush with valid output and valid input.
    step(1, ADDI_92, 32'h208, 1, 0);
    check("flush_ready", last_rdy, 0);
    check("flush_valid", bus.out_valid_o, 0);
    check("flush_pc_kept", bus.pc_o, 32'h204);
    step(1, ADDI_92, 32'h208, 0, 1);
    check("post_flush_pc", bus.pc_o, 32'h208);

    // Reset while holding a valid instruction.
    step(1, LW_X5, 32'h20C, 0, 0);
    do_reset();

    // Illegal encodings and LUI.
    step(1, 32'hABCDE0FF, 32'h300, 0, 1);
    check("ill7f_class", bus.ctrl_illegal_o, 1);
    check("ill7f_we", bus.rd_we_o, 0);
    check("ill7f_imm", bus.imm_o, 0);
    step(1, 32'h12345090, 32'h304, 0, 1);
    check("ill00_class", bus.ctrl_illegal_o, 1);
    check("ill00_we", bus.rd_we_o, 0);
    check("ill00_imm", bus.imm_o, 0);
    step(1, 32'h123451B7, 32'h308, 0, 1);
    check("lui_class", bus.ctrl_op_o, 1);
    check("lui_imm", bus.imm_o, 32'h1234_5000);

    // Randomized stream with a small register set to provoke hazards.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      w        = $urandom;
      w[6:0]   = opc_tab[$urandom_range(0, 10)];
      if ($urandom_range(0, 15) == 0) w[1:0] = 2'b00;
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8, w, $urandom, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    // Counter saturation against a stalled load.
    do_reset();
    step(1, LW_X5, 32'h400, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, ADD_567, 32'h404, 0, 0);
      check("sat_ready", last_rdy, 0);
    end
    check("sat_cnt", bus.bubble_cnt_o, (1 << CW) - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Registered instruction-decode stage for the PA-MIRI pipeline, parametrised in instruction, data and PC width. It sits between fetch and execute and classifies each instruction into one-hot control classes. It extracts register fields and builds the sign-extended immediate. It also detects load-use hazards, inserts one bubble per hazard, and moves instructions over a valid/ready handshake with flush support.

## Interface
- INSTR_SIZE, 32, instruction width; only 32 is legal
- XLEN, 32, immediate/data width; must be ≥ 32
- PC_W, 32, program-counter width
- CNT_W, 16, width of the bubble counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  stage accepts this cycle
- instr_i  in  INSTR_SIZE  instruction word
- pc_i  in  PC_W  instruction PC
- flush_i  in  1  discard the held instruction and refuse input this cycle
- out_valid_o  out  1  decoded instruction held
- out_ready_i  in  1  execute accepts
- ctrl_op_o, ctrl_ld_o, ctrl_st_o, ctrl_jm_o, ctrl_br_o, ctrl_illegal_o  out  1 each  one-hot class
- rs1_o, rs2_o, rd_o  out  5 each  register fields
- use_rs1_o, use_rs2_o, rd_we_o  out  1 each  operand usage and writeback enable
- funct3_o  out  3;  funct7_o  out  7
- imm_o  out  XLEN  sign-extended immediate
- pc_o  out  PC_W  PC of the held instruction
- bubble_cnt_o  out  CNT_W  saturating count of hazard bubbles

## Operation
- Opcodes come from the PARAMS_pkg constants:
  - OP 0110011, OP_IMM 0010011, LD 0000011, ST 0100011
  - BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111
- Class mapping:
  - ctrl_op: OP, OP_IMM, LUI, AUIPC
  - ctrl_ld: LD
  - ctrl_st: ST
  - ctrl_jm: JAL, JALR
  - ctrl_br: BR
  - ctrl_illegal: any other opcode, or instr[1:0] ≠ 2'b11
- While out_valid_o=1, exactly one class bit is high.
- use_rs1 is set for OP, OP_IMM, LD, ST, BR, JALR. use_rs2 is set for OP, ST, BR.
- rd_we is set for OP, OP_IMM, LD, JAL, JALR, LUI, AUIPC, only when rd ≠ 0.
- Illegal instructions still propagate. All use/we bits are 0, imm_o is 0, and fields are extracted raw.
- Immediate formats, all sign-extended from instr[31] to XLEN:
  - I-type: OP_IMM, LD, JALR
  - S-type: ST
  - B-type: BR, bit 0 = 0
  - U-type: LUI, AUIPC, low 12 bits = 0
  - J-type: JAL, bit 0 = 0
  - OP: imm_o = 0
- Hazard:
  - Condition: out_valid_o & ctrl_ld_o & rd_we_o, with the incoming instruction's decoded use_rs1 & rs1==rd_o, or use_rs2 & rs2==rd_o.
  - Response: the incoming instruction is not accepted. When the load leaves, the register goes empty, giving exactly one bubble. The instruction is accepted on the next cycle.
- in_ready_o = (!out_valid_o | out_ready_i) & !hazard & !flush_i, combinational.
- Register update, in priority order:
  - flush_i: out_valid_o ← 0.
  - else acceptance (in_valid_i & in_ready_o): all outputs load the decoded values, out_valid_o ← 1.
  - else out_ready_i: out_valid_o ← 0.
  - else: hold.
- Data outputs change only on acceptance.
- bubble_cnt_o increments by 1 each cycle with in_valid_i & hazard & !flush_i. It saturates at 2^CNT_W−1.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Full throughput: one instruction per cycle when there is no hazard and out_ready_i=1.
- Reset is asynchronous and takes effect immediately. Every output register goes to 0: out_valid_o, all ctrl, fields, imm_o, pc_o, bubble_cnt_o. in_ready_o is therefore 1 after reset if flush_i=0.
- Reset mid-transfer drops the held instruction and does not count a bubble.
- Backpressure: while out_valid_o=1 and out_ready_i=0, outputs are stable and in_ready_o=0.
- flush_i together with in_valid_i: the input is not accepted and not counted. out_valid_o is 0 on the next cycle, regardless of out_ready_i.
- Hazard against a load stalled by out_ready_i=0: in_ready_o stays 0 and the counter increments every such cycle.
- Sources of rd=x0 never trigger a hazard, because rd_we=0.

## Test plan
- Reset, then stream ADDI x1,x0,-1 (0xFFF00093), SW x1,8(x2), BEQ offset −4 → outputs one cycle later each:
  - ctrl_op, imm 0xFFFFFFFF
  - ctrl_st, imm 8
  - ctrl_br, imm 0xFFFFFFFC
  - in_ready_o stays 1 throughout.
- LW x5,0(x1) followed by ADD x6,x5,x7 with out_ready_i=1 → one cycle with in_valid_i=1 and in_ready_o=0; ADD emitted two cycles after LW; bubble_cnt_o=1.
- LW x0 then a consumer of x0, and LW x5 then ADDI x6,x4,1 → no bubble, bubble_cnt_o unchanged.
- Hold out_ready_i=0 for 3 cycles with a valid instruction held → outputs stable and in_ready_o=0. Release → next instruction accepted the same cycle.
- Assert flush_i with valid output and valid input → out_valid_o=0 next cycle, input not consumed. Also assert reset mid-stream → all outputs 0 immediately.
- Opcode 0x7F and instr[1:0]=2'b00 → ctrl_illegal_o=1, rd_we_o=0, imm_o=0. LUI 0x12345 → ctrl_op, imm_o 0x12345000.
